// File: rtl/pwm_capture.sv
// pwm_capture: measures the period and high time of an asynchronous PWM input
// and exposes the results over a Wishbone slave port.
//
// Ports
//   i_wb_clk            clock for all logic
//   i_wb_rst            asynchronous, active-high reset
//   i_wb_cyc/stb/we     Wishbone cycle, strobe, write enable
//   i_wb_adr[15:0]      register address
//   i_wb_data[31:0]     write data
//   o_wb_data[31:0]     registered read data, loaded on the acking edge
//   o_wb_ack            registered acknowledge, one cycle per access
//   i_pwm               asynchronous PWM input
//   o_irq               capture interrupt, level, active-high
//
// Register map
//   0 CTRL/STATUS  [0] enable [1] continuous [2] irq enable [3] VALID (W1C)
//                  [4] OVERFLOW (W1C) [5] OVERRUN (W1C) [7] soft reset (reads 0)
//                  [9:8] FSM state, read-only (0 IDLE, 1 ARM, 2 MEASURE)
//   2 DIVISOR      prescaler, tick every DIVISOR+1 clocks
//   4 PERIOD       last captured period in ticks (read-only)
//   6 HIGH         last captured high time in ticks (read-only)
//
// Build option: define PWM_CAPTURE_IRQ_EN to enable o_irq and CTRL bit 2.
// OVF_LIMIT is the counter value that flags OVERFLOW; leave it at all-ones
// for the full 32-bit range.
//
// State | meaning
// IDLE  | disabled, results held
// ARM   | enabled, waiting for the first rising edge
// MEAS  | counting ticks between rising edges

module pwm_capture #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] OVF_LIMIT   = 32'hFFFF_FFFF
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [15:0] i_wb_adr,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    input  logic        i_pwm,
    output logic        o_irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_prev_q;
    logic [31:0]            div_q, div_d;
    logic [31:0]            pre_q, pre_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [31:0]            hcnt_q, hcnt_d;
    logic [31:0]            period_q, period_d;
    logic [31:0]            high_q, high_d;
    logic                   en_q, en_d;
    logic                   cont_q, cont_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic                   ovr_q, ovr_d;
    logic                   ack_q;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            rmux;
    logic [31:0]            ctrl_rd;

    logic pwm_s, rise, tick;
    logic acc, wr_ctrl, wr_div, soft_rst;

`ifdef PWM_CAPTURE_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;
`else
    logic irq_en_q;
    assign irq_en_q = 1'b0;
`endif

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_prev_q;
    assign tick  = (pre_q == div_q);

    // The cycle after an ack is never accepted, so a held strobe is acked
    // every other cycle.
    assign acc      = i_wb_cyc & i_wb_stb & ~ack_q;
    assign wr_ctrl  = acc & i_wb_we & (i_wb_adr == 16'd0);
    assign wr_div   = acc & i_wb_we & (i_wb_adr == 16'd2);
    assign soft_rst = wr_ctrl & i_wb_data[7];

    assign ctrl_rd = {22'd0, state_q, 2'b00, ovr_q, ovf_q, valid_q,
                      irq_en_q, cont_q, en_q};

    always_comb begin
        rmux = 32'd0;
        case (i_wb_adr)
            16'd0:   rmux = ctrl_rd;
            16'd2:   rmux = div_q;
            16'd4:   rmux = period_q;
            16'd6:   rmux = high_q;
            default: rmux = 32'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        high_d   = high_q;
        rdata_d  = acc ? rmux : rdata_q;
        div_d    = wr_div ? i_wb_data : div_q;
        en_d     = wr_ctrl ? i_wb_data[0] : en_q;
        cont_d   = wr_ctrl ? i_wb_data[1] : cont_q;
        // W1C first; hardware sets below override it in the same cycle.
        valid_d  = valid_q & ~(wr_ctrl & i_wb_data[3]);
        ovf_d    = ovf_q   & ~(wr_ctrl & i_wb_data[4]);
        ovr_d    = ovr_q   & ~(wr_ctrl & i_wb_data[5]);
        pre_d    = (rise || tick) ? 32'd0 : pre_q + 32'd1;

        if (!en_q) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ARM;
                S_ARM: begin
                    if (rise) begin
                        state_d = S_MEAS;
                        cnt_d   = 32'd0;
                        hcnt_d  = 32'd0;
                    end
                end
                S_MEAS: begin
                    // Overflow is checked first: cnt+1 would wrap.
                    if (cnt_q == OVF_LIMIT) begin
                        ovf_d   = 1'b1;
                        state_d = S_ARM;
                    end else if (rise) begin
                        period_d = cnt_q + 32'd1;
                        high_d   = hcnt_q + 32'd1;
                        valid_d  = 1'b1;
                        if (valid_q) ovr_d = 1'b1;
                        cnt_d    = 32'd0;
                        hcnt_d   = 32'd0;
                        if (!cont_q) begin
                            en_d    = 1'b0;
                            state_d = S_IDLE;
                        end
                    end else if (tick) begin
                        cnt_d = cnt_q + 32'd1;
                        if (pwm_s) hcnt_d = hcnt_q + 32'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (soft_rst) begin
            state_d  = S_IDLE;
            cnt_d    = 32'd0;
            hcnt_d   = 32'd0;
            period_d = 32'd0;
            high_d   = 32'd0;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
            ovr_d    = 1'b0;
            en_d     = 1'b0;
            cont_d   = 1'b0;
            pre_d    = 32'd0;
        end
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            pwm_prev_q <= 1'b0;
            div_q      <= 32'd0;
            pre_q      <= 32'd0;
            cnt_q      <= 32'd0;
            hcnt_q     <= 32'd0;
            period_q   <= 32'd0;
            high_q     <= 32'd0;
            en_q       <= 1'b0;
            cont_q     <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            ovr_q      <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], i_pwm};
            pwm_prev_q <= pwm_s;
            div_q      <= div_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            period_q   <= period_d;
            high_q     <= high_d;
            en_q       <= en_d;
            cont_q     <= cont_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            ovr_q      <= ovr_d;
            ack_q      <= acc;
            rdata_q    <= rdata_d;
        end
    end

`ifdef PWM_CAPTURE_IRQ_EN
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_ctrl)  irq_en_d = i_wb_data[2];
        if (soft_rst) irq_en_d = 1'b0;
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q & (valid_q | ovf_q | ovr_q);
        end
    end

    assign o_irq = irq_q;
`else
    assign o_irq = 1'b0;
`endif

    assign o_wb_data = rdata_q;
    assign o_wb_ack  = ack_q;

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

    logic        i_wb_clk;
    logic        i_wb_rst;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [15:0] i_wb_adr;
    logic [31:0] i_wb_data;
    logic [31:0] o_wb_data;
    logic        o_wb_ack;
    logic        i_pwm;
    logic        o_irq;

`ifdef PWM_CAPTURE_IRQ_EN
    localparam logic [31:0] IRQB   = 32'h4;
    localparam logic [31:0] IRQ_ON = 32'd1;
`else
    localparam logic [31:0] IRQB   = 32'h0;
    localparam logic [31:0] IRQ_ON = 32'd0;
`endif

    int nvec = 0;
    int nerr = 0;

    int pwm_mode = 0;   // 0 low, 1 held high, 2 periodic
    int pwm_per  = 100;
    int pwm_hi   = 30;
    int ph       = 0;

    logic [31:0] exp_lo_q[$];
    logic [31:0] exp_hi_q[$];
    string       tag_q[$];

    pwm_capture #(
        .SYNC_STAGES(2),
        .OVF_LIMIT  (32'd1000)
    ) dut (
        .i_wb_clk (i_wb_clk),
        .i_wb_rst (i_wb_rst),
        .i_wb_cyc (i_wb_cyc),
        .i_wb_stb (i_wb_stb),
        .i_wb_we  (i_wb_we),
        .i_wb_adr (i_wb_adr),
        .i_wb_data(i_wb_data),
        .o_wb_data(o_wb_data),
        .o_wb_ack (o_wb_ack),
        .i_pwm    (i_pwm),
        .o_irq    (o_irq)
    );

    initial begin
        i_wb_clk = 1'b0;
        forever #5 i_wb_clk = ~i_wb_clk;
    end

    initial begin
        i_pwm = 1'b0;
        forever begin
            @(negedge i_wb_clk);
            if (pwm_mode == 2) begin
                i_pwm = (ph < pwm_hi);
                ph = (ph + 1 >= pwm_per) ? 0 : ph + 1;
            end else begin
                i_pwm = (pwm_mode == 1);
                ph = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] lo, input logic [31:0] hi);
        nvec++;
        assert (obs === lo || (obs >= lo && obs <= hi)) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h..0x%0h", tag, obs, lo, hi);
        end
    endtask

    task automatic wb_op(input logic we, input logic [15:0] adr,
                         input logic [31:0] dat, input string tag);
        logic        got;
        logic [31:0] lo, hi;
        string       t;
        got = 1'b0;
        @(negedge i_wb_clk);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_adr  = adr;
        i_wb_data = dat;
        for (int k = 0; k < 8; k++) begin
            @(posedge i_wb_clk);
            #1;
            if (o_wb_ack) begin
                got = 1'b1;
                break;
            end
        end
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        chk({tag, "_ack"}, {31'd0, got}, 32'd1, 32'd1);
        if (!we) begin
            lo = exp_lo_q.pop_front();
            hi = exp_hi_q.pop_front();
            t  = tag_q.pop_front();
            chk(t, o_wb_data, lo, hi);
        end
    endtask

    task automatic wb_read(input logic [15:0] adr, input logic [31:0] lo,
                           input logic [31:0] hi, input string tag);
        exp_lo_q.push_back(lo);
        exp_hi_q.push_back(hi);
        tag_q.push_back(tag);
        wb_op(1'b0, adr, 32'd0, tag);
    endtask

    task automatic wb_write(input logic [15:0] adr, input logic [31:0] dat,
                            input string tag);
        wb_op(1'b1, adr, dat, tag);
    endtask

    initial begin
        i_wb_rst  = 1'b1;
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_wb_adr  = 16'd0;
        i_wb_data = 32'd0;
        repeat (3) @(negedge i_wb_clk);
        i_wb_rst = 1'b0;
        @(negedge i_wb_clk);

        // Reset state
        chk("rst_ack", {31'd0, o_wb_ack}, 32'd0, 32'd0);
        chk("rst_data", o_wb_data, 32'd0, 32'd0);
        chk("rst_irq", {31'd0, o_irq}, 32'd0, 32'd0);
        wb_read(16'd0, 32'd0, 32'd0, "rst_ctrl");
        wb_read(16'd2, 32'd0, 32'd0, "rst_div");
        wb_read(16'd4, 32'd0, 32'd0, "rst_period");
        wb_read(16'd6, 32'd0, 32'd0, "rst_high");

        // Unmapped accesses
        wb_write(16'd8, 32'h0000_FFFF, "unmap_wr");
        wb_read(16'd8, 32'd0, 32'd0, "unmap_rd");
        wb_read(16'd2, 32'd0, 32'd0, "unmap_div_kept");

        // Held strobe: ack every other cycle
        repeat (2) @(negedge i_wb_clk);
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we  = 1'b0;
        i_wb_adr = 16'd2;
        for (int i = 0; i < 4; i++) begin
            @(posedge i_wb_clk);
            #1;
            chk("b2b_ack", {31'd0, o_wb_ack}, (i % 2 == 0) ? 32'd1 : 32'd0,
                (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;

        // DIVISOR=0, continuous, period 100 / high 30
        wb_write(16'd2, 32'd0, "t1_div");
        wb_write(16'd0, 32'h03 | IRQB, "t1_ctrl");
        pwm_per = 100; pwm_hi = 30; pwm_mode = 2;
        repeat (50) @(negedge i_wb_clk);
        wb_read(16'd0, 32'h203 | IRQB, 32'h203 | IRQB, "t1_ctrl_novalid");
        repeat (100) @(negedge i_wb_clk);
        wb_read(16'd4, 32'd100, 32'd100, "t1_period");
        wb_read(16'd6, 32'd30, 32'd30, "t1_high");
        wb_read(16'd0, 32'h20B | IRQB, 32'h20B | IRQB, "t1_ctrl_valid");
        chk("t1_irq", {31'd0, o_irq}, IRQ_ON, IRQ_ON);

        // Second capture with VALID still set -> OVERRUN; then W1C
        repeat (100) @(negedge i_wb_clk);
        wb_read(16'd0, 32'h22B | IRQB, 32'h22B | IRQB, "t1_overrun");
        wb_write(16'd0, 32'h38, "t1_w1c");
        repeat (3) @(negedge i_wb_clk);
        wb_read(16'd0, 32'd0, 32'd0, "t1_ctrl_cleared");
        chk("t1_irq_cleared", {31'd0, o_irq}, 32'd0, 32'd0);
        wb_read(16'd4, 32'd100, 32'd100, "t1_period_kept");
        pwm_mode = 0;

        // Soft reset keeps DIVISOR
        wb_write(16'd2, 32'd3, "sr_div");
        wb_write(16'd0, 32'h80, "sr_ctrl");
        wb_read(16'd0, 32'd0, 32'd0, "sr_ctrl_rd");
        wb_read(16'd4, 32'd0, 32'd0, "sr_period");
        wb_read(16'd6, 32'd0, 32'd0, "sr_high");
        wb_read(16'd2, 32'd3, 32'd3, "sr_div_kept");

        // DIVISOR=3, period 400 / high 100
        wb_write(16'd0, 32'h03, "t2_ctrl");
        pwm_per = 400; pwm_hi = 100; pwm_mode = 2;
        repeat (500) @(negedge i_wb_clk);
        wb_read(16'd4, 32'd100, 32'd100, "t2_period");
        wb_read(16'd6, 32'd24, 32'd26, "t2_high");
        pwm_mode = 0;

        // One-shot, three pulses
        wb_write(16'd0, 32'h80, "t3_sr");
        wb_write(16'd2, 32'd0, "t3_div");
        wb_write(16'd0, 32'h01 | IRQB, "t3_ctrl");
        pwm_per = 100; pwm_hi = 30; pwm_mode = 2;
        repeat (280) @(negedge i_wb_clk);
        pwm_mode = 0;
        wb_read(16'd0, 32'h08 | IRQB, 32'h08 | IRQB, "t3_ctrl_oneshot");
        wb_read(16'd4, 32'd100, 32'd100, "t3_period");
        wb_read(16'd6, 32'd30, 32'd30, "t3_high");
        chk("t3_irq", {31'd0, o_irq}, IRQ_ON, IRQ_ON);

        // Input held high -> OVERFLOW, back to ARM
        wb_write(16'd0, 32'h80, "t4_sr");
        wb_write(16'd0, 32'h03 | IRQB, "t4_ctrl");
        pwm_mode = 1;
        repeat (1100) @(negedge i_wb_clk);
        wb_read(16'd0, 32'h113 | IRQB, 32'h113 | IRQB, "t4_overflow");
        wb_read(16'd4, 32'd0, 32'd0, "t4_period");
        wb_read(16'd6, 32'd0, 32'd0, "t4_high");
        chk("t4_irq", {31'd0, o_irq}, IRQ_ON, IRQ_ON);
        pwm_mode = 0;

        // Hard reset mid-MEASURE
        wb_write(16'd0, 32'h80, "t5_sr");
        wb_write(16'd0, 32'h03 | IRQB, "t5_ctrl");
        pwm_per = 100; pwm_hi = 30; pwm_mode = 2;
        repeat (150) @(negedge i_wb_clk);
        wb_read(16'd4, 32'd100, 32'd100, "t5_period_pre");
        @(negedge i_wb_clk);
        i_wb_rst = 1'b1;
        #1;
        chk("t5_rst_ack", {31'd0, o_wb_ack}, 32'd0, 32'd0);
        chk("t5_rst_data", o_wb_data, 32'd0, 32'd0);
        chk("t5_rst_irq", {31'd0, o_irq}, 32'd0, 32'd0);
        repeat (3) @(negedge i_wb_clk);
        i_wb_rst = 1'b0;
        pwm_mode = 0;
        repeat (5) @(negedge i_wb_clk);
        chk("t5_post_ack", {31'd0, o_wb_ack}, 32'd0, 32'd0);
        wb_read(16'd0, 32'd0, 32'd0, "t5_ctrl");
        wb_read(16'd2, 32'd0, 32'd0, "t5_div");
        wb_read(16'd4, 32'd0, 32'd0, "t5_period");
        wb_read(16'd6, 32'd0, 32'd0, "t5_high");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2 (minimum 2), the number of synchronizer flops on i_pwm.
REQ-002 SHALL provide i_wb_clk  input  1  Wishbone clock; all logic runs on it.
REQ-003 SHALL provide i_wb_rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL provide i_wb_cyc, i_wb_stb, i_wb_we  input  1 each  Wishbone cycle, strobe and write enable.
REQ-005 SHALL provide i_wb_adr  input  16  register address; i_wb_data  input  32  write data.
REQ-006 SHALL provide o_wb_data  output  32  registered read data; o_wb_ack  output  1  registered acknowledge.
REQ-007 SHALL provide i_pwm  input  1  asynchronous PWM signal under measurement.
REQ-008 SHALL provide o_irq  output  1  capture interrupt, level, active-high.

Function
REQ-009 SHALL decode these registers: 0 CTRL/STATUS, 2 DIVISOR (32-bit), 4 PERIOD (read-only), 6 HIGH (read-only).
REQ-010 SHALL define CTRL bits as follows: 0 enable; 1 continuous (0 = one-shot); 2 irq enable; 3 VALID (W1C); 4 OVERFLOW (W1C); 5 OVERRUN (W1C); 7 soft reset (self-clearing, reads 0).
REQ-011 SHALL assert o_wb_ack for exactly one cycle on the cycle after i_wb_cyc&i_wb_stb, and SHALL ignore the following cycle so that back-to-back strobes are acked every other cycle.
REQ-012 SHALL load o_wb_data with the addressed register in the same edge that sets o_wb_ack; unmapped reads SHALL return 0, and unmapped writes SHALL be acked and ignored.
REQ-013 SHALL pass i_pwm through SYNC_STAGES flops, then a rising/falling edge detector, so an edge is detected SYNC_STAGES+1 cycles after i_pwm changes.
REQ-014 SHALL generate a tick every DIVISOR+1 clock cycles (DIVISOR=0 gives a tick every cycle); the prescaler SHALL restart on every detected rising edge.
REQ-015 SHALL implement states IDLE, ARM and MEASURE.
REQ-016 SHALL transition IDLE->ARM when enable=1, ARM->MEASURE on a rising edge (clearing cnt and hcnt), and any state->IDLE when enable=0; results SHALL be retained on that transition.
REQ-017 SHALL, in MEASURE, increment cnt on each tick and increment hcnt on each tick while the synchronized input is high.
REQ-018 SHALL, on a rising edge in MEASURE, load PERIOD=cnt+1 and HIGH=hcnt+1, set VALID, and restart cnt/hcnt at 0; with DIVISOR=0 this gives the exact period and high time in clocks.
REQ-019 SHALL set OVERRUN if VALID is already 1 when a new capture loads.
REQ-020 SHALL, in one-shot mode, clear enable and go to IDLE after the first capture.
REQ-021 SHALL, if cnt reaches 0xFFFFFFFF, set OVERFLOW, leave PERIOD/HIGH unchanged and return to ARM.
REQ-022 SHALL give hardware set priority over a W1C in the same cycle.
REQ-023 SHALL, on soft reset, clear the state to IDLE and clear cnt, hcnt, PERIOD, HIGH, flags and CTRL[2:0]; DIVISOR SHALL be kept.

Reset
REQ-024 SHALL, on i_wb_rst, clear all registers, counters, synchronizer flops, o_wb_ack, o_wb_data and o_irq to 0, with the state set to IDLE.
REQ-025 SHALL abandon any in-flight measurement or bus access when reset asserts mid-operation, and SHALL issue no ack after reset release.

Configuration
REQ-026 SHALL, when macro PWM_CAPTURE_IRQ_EN is defined, drive o_irq = irq_enable & (VALID | OVERFLOW | OVERRUN).
REQ-027 SHALL, when PWM_CAPTURE_IRQ_EN is undefined, tie o_irq to 0, with CTRL bit 2 reading 0 and writes to it ignored.

Verification
REQ-028 SHALL cover: DIVISOR=0, continuous, i_pwm period 100 clocks, high 30 -> PERIOD=100, HIGH=30, VALID=1 after the second rising edge.
REQ-029 SHALL cover: DIVISOR=3, period 400 clocks, high 100 -> PERIOD=100, HIGH=25 (±1).
REQ-030 SHALL cover: one-shot, three pulses -> exactly one capture, enable reads 0, state IDLE.
REQ-031 SHALL cover: i_pwm held at 1 after the first rising edge -> OVERFLOW=1, with o_irq=1 when the macro is defined and irq enable=1.
REQ-032 SHALL cover: VALID left uncleared across two captures -> OVERRUN=1; writing 0x38 to CTRL -> bits 3-5 clear and o_irq=0.
REQ-033 SHALL cover: i_wb_rst asserted mid-MEASURE -> all reads return 0 and o_wb_ack=0 until the next strobe.
